// File: rtl/muldiv_unit_pkg.sv
// Shared RISC-V core defines plus M-extension funct3 helpers used by the multiply/divide unit.
`ifndef RISC_V_DEFINES_SVH
`define RISC_V_DEFINES_SVH
`define REG_WIDTH      32
`define REG_ADDR_WIDTH 5
`define F3_MUL         3'b000
`define F3_MULH        3'b001
`define F3_MULHSU      3'b010
`define F3_MULHU       3'b011
`define F3_DIV         3'b100
`define F3_DIVU        3'b101
`define F3_REM         3'b110
`define F3_REMU        3'b111
`endif

package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = `F3_MUL;
  localparam logic [2:0] F3_MULH   = `F3_MULH;
  localparam logic [2:0] F3_MULHSU = `F3_MULHSU;
  localparam logic [2:0] F3_MULHU  = `F3_MULHU;
  localparam logic [2:0] F3_DIV    = `F3_DIV;
  localparam logic [2:0] F3_DIVU   = `F3_DIVU;
  localparam logic [2:0] F3_REM    = `F3_REM;
  localparam logic [2:0] F3_REMU   = `F3_REMU;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == F3_DIV) || (op == F3_DIVU) || (op == F3_REM) || (op == F3_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == F3_REM) || (op == F3_REMU);
  endfunction

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == F3_MUL) || (op == F3_MULH) || (op == F3_MULHSU) ||
           (op == F3_DIV) || (op == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shared 2W shift register,
// results written straight into the register file write port.
//   state | meaning
//   IDLE  | waiting for start
//   PREP  | operand magnitudes, sign flags, special-case detection
//   CALC  | W shift-add / shift-subtract iterations
//   FIX   | sign correction and result select
//   DONE  | one-cycle write-back pulse
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int REG_WIDTH      = `REG_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [REG_WIDTH-1:0]      rs1_val,
  input  logic [REG_WIDTH-1:0]      rs2_val,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] addr_rd,
  output logic [REG_WIDTH-1:0]      data_rd
);

  localparam int W = REG_WIDTH;
  localparam logic [W-1:0] CNT_LOAD = W'(W);
  localparam logic [W-1:0] INT_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t                    state, next_state;
  logic [2:0]                op_q;
  logic [W-1:0]              a_q, b_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [2*W-1:0]            acc;
  logic [W-1:0]              cnt;
  logic                      neg_res, neg_rem;

  logic                      accept, sign_a, sign_b, div_zero, div_ovf, special;
  logic [W-1:0]              mag_a, mag_b, special_res, fix_res, quo_fix, rem_fix;
  logic [W:0]                mul_sum, mul_hi, rem_sh, diff;
  logic [2*W-1:0]            mul_next, div_next, prod;

  always_comb begin
    accept   = start && ((state == IDLE) || (state == DONE));
    sign_a   = rs1_signed(op_q) && a_q[W-1];
    sign_b   = rs2_signed(op_q) && b_q[W-1];
    mag_a    = sign_a ? -a_q : a_q;
    mag_b    = sign_b ? -b_q : b_q;
    div_zero = is_div_op(op_q) && (b_q == '0);
    div_ovf  = ((op_q == F3_DIV) || (op_q == F3_REM)) && (a_q == INT_MIN) && (b_q == '1);
    special  = div_zero || div_ovf;

    if (div_zero) special_res = is_rem_op(op_q) ? a_q : '1;
    else          special_res = is_rem_op(op_q) ? '0 : INT_MIN;

    // Multiply: conditional add of the multiplicand into the high half, then shift right.
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, b_q};
    mul_hi   = acc[0] ? mul_sum : {1'b0, acc[2*W-1:W]};
    mul_next = {mul_hi, acc[W-1:1]};

    // Divide: restoring step, quotient bits shift in at the bottom.
    rem_sh   = acc[2*W-1:W-1];
    diff     = rem_sh - {1'b0, b_q};
    div_next = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                       : {diff[W-1:0],   acc[W-2:0], 1'b1};

    prod    = neg_res ? -acc : acc;
    quo_fix = neg_res ? -acc[W-1:0] : acc[W-1:0];
    rem_fix = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op_q)
      F3_MUL:                       fix_res = prod[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*W-1:W];
      F3_DIV, F3_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = PREP;
      PREP:    next_state = special ? DONE : CALC;
      CALC:    if (cnt == W'(1)) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    next_state = start ? PREP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      op_q <= funct3;
      a_q  <= rs1_val;
      b_q  <= rs2_val;
      rd_q <= rd_in;
    end else if (state == PREP) begin
      acc     <= {{W{1'b0}}, mag_a};
      b_q     <= mag_b;
      cnt     <= CNT_LOAD;
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
    end else if (state == CALC) begin
      acc <= is_div_op(op_q) ? div_next : mul_next;
      cnt <= cnt - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      addr_rd <= '0;
      data_rd <= '0;
    end else begin
      busy  <= (next_state == PREP) || (next_state == CALC) || (next_state == FIX);
      done  <= (next_state == DONE);
      wr_en <= (next_state == DONE);
      if (next_state == DONE) begin
        addr_rd <= rd_q;
        data_rd <= (state == FIX) ? fix_res : special_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [W-1:0]  rs1_val = '0;
  logic [W-1:0]  rs2_val = '0;
  logic [AW-1:0] rd_in = '0;
  logic          busy, done, wr_en;
  logic [AW-1:0] addr_rd;
  logic [W-1:0]  data_rd;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.REG_WIDTH(W), .REG_ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .addr_rd (addr_rd),
    .data_rd (data_rd)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    logic   ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = (ua * ub) >> 32;
      3'd4: r = (b == 0) ? -1 : (ovf ? sa : sa / sb);
      3'd5: r = (b == 0) ? -1 : ua / ub;
      3'd6: r = (b == 0) ? sa : (ovf ? 0 : sa % sb);
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  task automatic set_inputs(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
    start   = 1'b1;
    funct3  = op;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
  endtask

  // Assumes start is already presented for this op; the next rising edge accepts it.
  task automatic wait_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input bit glitch, input bit keep);
    logic [31:0] exp;
    int          n, busy_n, exp_lat;
    string       t;
    exp     = ref_result(op, a, b);
    exp_lat = is_special(op, a, b) ? 2 : W + 3;
    t       = $sformatf("op%0d %h,%h", op, a, b);
    @(posedge clk); #1;
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 5'($urandom);
    n       = 1;
    busy_n  = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (glitch && n == 10) begin
        start   = 1'b1;
        funct3  = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
      end
      if (glitch && n == 12) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check_val({t, " latency"}, n, exp_lat);
    check_val({t, " busy_cycles"}, busy_n, exp_lat - 1);
    check_val({t, " data_rd"}, data_rd, exp);
    check_val({t, " addr_rd"}, addr_rd, rd);
    check_val({t, " wr_en"}, wr_en, 1);
    check_val({t, " busy_in_done"}, busy, 0);
    if (!keep) begin
      @(posedge clk); #1;
      check_val({t, " done_drop"}, done, 0);
      check_val({t, " wr_en_drop"}, wr_en, 0);
      check_val({t, " data_hold"}, data_rd, exp);
      check_val({t, " addr_hold"}, addr_rd, rd);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    set_inputs(op, a, b, rd);
    wait_result(op, a, b, rd, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset wr_en", wr_en, 0);
    check_val("reset addr_rd", addr_rd, 0);
    check_val("reset data_rd", data_rd, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // First edge after reset release accepts; rd=0 must still write.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(3'd5, 32'd5, 32'd0, 5'd8);
    run_op(3'd6, 32'd5, 32'd0, 5'd9);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);

    set_inputs(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd12);
    wait_result(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd12, 1'b1, 1'b0);

    set_inputs(3'd5, 32'd100, 32'd7, 5'd6);
    wait_result(3'd5, 32'd100, 32'd7, 5'd6, 1'b0, 1'b1);
    set_inputs(3'd7, 32'd100, 32'd7, 5'd7);
    wait_result(3'd7, 32'd100, 32'd7, 5'd7, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      run_op(op, a, b, 5'($urandom));
    end

    set_inputs(3'd0, 32'd9, 32'd9, 5'd3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("midreset busy", busy, 0);
    check_val("midreset done", done, 0);
    check_val("midreset wr_en", wr_en, 0);
    check_val("midreset data_rd", data_rd, 0);
    check_val("midreset addr_rd", addr_rd, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 5'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter REG_WIDTH, default `REG_WIDTH (32), operand/result width W.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default `REG_ADDR_WIDTH (5), destination address width.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  operation request; accepted only when busy=0.
REQ-006 SHALL have port funct3  input  3  M-extension op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000..111).
REQ-007 SHALL have ports rs1_val, rs2_val  input  W  operands, as produced by the register file's data_rs1/data_rs2.
REQ-008 SHALL have port rd_in  input  REG_ADDR_WIDTH  destination register address.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle result pulse.
REQ-011 SHALL have ports wr_en  output  1, addr_rd  output  REG_ADDR_WIDTH, data_rd  output  W; these drive the register file write port directly.

Function
REQ-012 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-013 SHALL, on a rising edge with start=1 in IDLE or DONE, capture funct3, rs1_val, rs2_val and rd_in, then enter PREP; operands SHALL be ignored after capture.
REQ-014 SHALL ignore start in PREP, CALC and FIX (no queuing, no effect on the current operation).
REQ-015 SHALL, in PREP, form operand magnitudes and sign flags: MUL/MULH/DIV/REM treat both operands as signed, MULHSU only rs1, MULHU/DIVU/REMU neither.
REQ-016 SHALL, in PREP, detect divide-by-zero (rs2=0) and signed overflow (DIV/REM, rs1=2^(W-1), rs2=all ones) and go directly to DONE.
REQ-017 SHALL run exactly W CALC cycles via a W-bit iteration counter: radix-2 shift-add into a 2W product for multiply, restoring shift-subtract for divide.
REQ-018 SHALL, in FIX, negate the product if operand signs differ, negate the quotient if signed and signs differ, and give the remainder the sign of rs1.
REQ-019 SHALL select the result: MUL low W bits; MULH/MULHSU/MULHU high W bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-020 SHALL return on divide-by-zero quotient all ones and remainder rs1; on overflow quotient 2^(W-1) and remainder 0.
REQ-021 SHALL assert done and wr_en together for exactly one cycle in DONE, with data_rd and addr_rd valid in that cycle; wr_en SHALL assert even for rd_in=0 (register file discards x0 writes).
REQ-022 SHALL assert done W+3 cycles after the accepting edge on the normal path and 2 cycles after it on the special-case path.
REQ-023 SHALL hold busy=1 in PREP, CALC and FIX, and busy=0 in IDLE and DONE.
REQ-024 SHALL go from DONE to IDLE when start=0 and to PREP when start=1 (back-to-back).
REQ-025 SHALL drive all outputs from registers; data_rd and addr_rd SHALL hold their last values outside DONE.

Reset
REQ-026 SHALL, on reset_n low, immediately force state IDLE and clear busy, done, wr_en, addr_rd, data_rd, counter and datapath registers to 0, including mid-operation.
REQ-027 SHALL accept start on the first rising edge after reset_n deasserts.

Structure
REQ-028 SHALL take REG_WIDTH, REG_ADDR_WIDTH and the eight funct3 M-extension encodings from the shared risc_v_defines include; the FSM state encoding SHALL stay local.
REQ-029 SHALL be a single module with no sub-module; multiply and divide SHALL share the 2W shift register and the iteration counter.

Verification
REQ-030 SHALL cover MUL 7 x 0xFFFFFFFD (-3) -> data_rd 0xFFFFFFEB, done 35 cycles after start, busy high 34 cycles.
REQ-031 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 SHALL cover DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-033 SHALL cover DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with done at 2 cycles; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0.
REQ-034 SHALL cover start pulses during CALC -> ignored with the original result unchanged, and start held high in DONE -> the second operation completes 35 cycles later.
REQ-035 SHALL cover reset_n low mid-CALC -> busy, done, wr_en, data_rd = 0 without a clock edge, and a subsequent MUL 3 x 4 -> 12 with correct latency.
